// File: rtl/ctrl_pipe_unit.sv
// RV32I control pipeline: decodes the opcode in ID, carries control and rd
// through EX/MEM/WB, inserts load-use bubbles and counts inserted bubbles.
module ctrl_pipe_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter bit EN_HAZARD    = 1'b1,
  parameter bit RD0_SUPPRESS = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [6:0]            opcode,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ext_stall,
  input  logic                  flush,
  input  logic                  cnt_clr,
  output logic                  hz_stall,
  output logic [11:0]           ex_ctrl,
  output logic [11:0]           mem_ctrl,
  output logic [11:0]           wb_ctrl,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [CNT_W-1:0]      bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Bundle layout, MSB first:
  // illegal, jump, branch, memread, memwrite, memtoreg, alusrc, alusrc_pc, regwrite, aluop[2:0]
  function automatic logic [11:0] decode_fn(input logic [6:0] op);
    logic [11:0] c;
    case (op)
      7'b0000011: c = 12'h168;
      7'b0100011: c = 12'h0A0;
      7'b0110011: c = 12'h00A;
      7'b1100011: c = 12'h201;
      7'b0010011: c = 12'h02B;
      7'b1101111: c = 12'h428;
      7'b1100111: c = 12'h428;
      7'b0110111: c = 12'h02C;
      7'b0010111: c = 12'h038;
      default:    c = 12'h800;
    endcase
    return c;
  endfunction

  function automatic logic uses_rs1_fn(input logic [6:0] op);
    logic u;
    case (op)
      7'b0000011, 7'b0100011, 7'b0110011,
      7'b1100011, 7'b0010011, 7'b1100111: u = 1'b1;
      default:                            u = 1'b0;
    endcase
    return u;
  endfunction

  function automatic logic uses_rs2_fn(input logic [6:0] op);
    logic u;
    case (op)
      7'b0110011, 7'b0100011, 7'b1100011: u = 1'b1;
      default:                            u = 1'b0;
    endcase
    return u;
  endfunction

  logic [11:0]           dec_ctrl_s;
  logic                  hz_s;
  logic                  bubble_s;
  logic                  count_s;
  logic [11:0]           ex_ctrl_r, mem_ctrl_r, wb_ctrl_r;
  logic [REG_ADDR_W-1:0] ex_rd_r, mem_rd_r, wb_rd_r;
  logic [CNT_W-1:0]      cnt_r;

  // Decode with rd=x0 write suppression, plus load-use hazard detection
  always_comb begin
    dec_ctrl_s = decode_fn(opcode);
    if (RD0_SUPPRESS && (id_rd == {REG_ADDR_W{1'b0}})) begin
      dec_ctrl_s[3] = 1'b0;
    end else begin
      dec_ctrl_s[3] = dec_ctrl_s[3];
    end
    hz_s = 1'b0;
    if (EN_HAZARD && id_valid && !flush && ex_ctrl_r[8] &&
        (ex_rd_r != {REG_ADDR_W{1'b0}})) begin
      hz_s = (uses_rs1_fn(opcode) && (ex_rd_r == id_rs1)) ||
             (uses_rs2_fn(opcode) && (ex_rd_r == id_rs2));
    end else begin
      hz_s = 1'b0;
    end
    bubble_s = flush | hz_s | ~id_valid;
    count_s  = flush | hz_s;
  end

  // Stage registers: reset empties all stages, ext_stall freezes them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_ctrl_r  <= 12'h000;
      mem_ctrl_r <= 12'h000;
      wb_ctrl_r  <= 12'h000;
      ex_rd_r    <= {REG_ADDR_W{1'b0}};
      mem_rd_r   <= {REG_ADDR_W{1'b0}};
      wb_rd_r    <= {REG_ADDR_W{1'b0}};
    end else if (ext_stall) begin
      ex_ctrl_r  <= ex_ctrl_r;
      mem_ctrl_r <= mem_ctrl_r;
      wb_ctrl_r  <= wb_ctrl_r;
      ex_rd_r    <= ex_rd_r;
      mem_rd_r   <= mem_rd_r;
      wb_rd_r    <= wb_rd_r;
    end else begin
      ex_ctrl_r  <= bubble_s ? 12'h000 : dec_ctrl_s;
      ex_rd_r    <= bubble_s ? {REG_ADDR_W{1'b0}} : id_rd;
      mem_ctrl_r <= ex_ctrl_r;
      mem_rd_r   <= ex_rd_r;
      wb_ctrl_r  <= mem_ctrl_r;
      wb_rd_r    <= mem_rd_r;
    end
  end

  // Saturating bubble counter; a frozen edge inserts nothing so counts nothing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!ext_stall && count_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign hz_stall   = hz_s;
  assign ex_ctrl    = ex_ctrl_r;
  assign mem_ctrl   = mem_ctrl_r;
  assign wb_ctrl    = wb_ctrl_r;
  assign ex_rd      = ex_rd_r;
  assign mem_rd     = mem_rd_r;
  assign wb_rd      = wb_rd_r;
  assign bubble_cnt = cnt_r;

endmodule
